// File: rtl/clk_div_gen_if.sv
// Configuration and clock-output bundle for clk_div_gen.
// master drives configuration/power-down; slave (the generator) returns ack, lock and clocks.
interface clk_div_gen_if #(
  parameter int NUM_OUT = 4,
  parameter int DIV_W   = 8
);
  logic                       PWRDWN;
  logic                       CFG_LOAD;
  logic [NUM_OUT*DIV_W-1:0]   CFG_DIV;
  logic [NUM_OUT*DIV_W-1:0]   CFG_PHASE;
  logic                       CFG_ACK;
  logic                       LOCKED;
  logic [NUM_OUT-1:0]         CLKOUT;
  logic [NUM_OUT-1:0]         CE;

  modport master (
    output PWRDWN, CFG_LOAD, CFG_DIV, CFG_PHASE,
    input  CFG_ACK, LOCKED, CLKOUT, CE
  );

  modport slave (
    input  PWRDWN, CFG_LOAD, CFG_DIV, CFG_PHASE,
    output CFG_ACK, LOCKED, CLKOUT, CE
  );
endinterface

// File: rtl/clk_div_gen.sv
// MMCM stand-in: NUM_OUT programmable divided clocks/enables behind a modelled lock delay.
// All outputs registered (1-cycle input-to-output latency); no backpressure, CFG_LOAD always accepted.
module clk_div_gen #(
  parameter int NUM_OUT     = 4,
  parameter int DIV_W       = 8,
  parameter int LOCK_CYCLES = 64
) (
  input  logic            CLKIN1,
  input  logic            RST,
  clk_div_gen_if.slave    bus
);

  localparam int LCW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  typedef enum logic {
    ST_WAIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t              state, state_nx;
  logic [LCW-1:0]      lock_cnt, lock_cnt_nx;

  logic [DIV_W-1:0]    div_q   [NUM_OUT];
  logic [DIV_W-1:0]    div_nx  [NUM_OUT];
  logic [DIV_W-1:0]    ph_q    [NUM_OUT];
  logic [DIV_W-1:0]    ph_nx   [NUM_OUT];
  logic [DIV_W-1:0]    cnt     [NUM_OUT];
  logic [DIV_W-1:0]    cnt_nx  [NUM_OUT];

  logic [DIV_W-1:0]    d_eff   [NUM_OUT];
  logic [DIV_W-1:0]    ph_eff  [NUM_OUT];
  logic [DIV_W:0]      half    [NUM_OUT];
  logic [DIV_W-1:0]    cnt_adv [NUM_OUT];

  logic [NUM_OUT-1:0]  clkout_q, clkout_nx;
  logic [NUM_OUT-1:0]  ce_q, ce_nx;
  logic                locked_q, locked_nx;
  logic                ack_q, ack_nx;

  function automatic logic clk_of(input logic [DIV_W-1:0] c, input logic [DIV_W:0] h);
    return ({1'b0, c} < h);
  endfunction

  function automatic logic ce_of(input logic [DIV_W-1:0] c);
    return (c == '0);
  endfunction

  // Ratio 0 means 1; an out-of-range phase falls back to 0. Half is ceil(D/2).
  always_comb begin
    for (int i = 0; i < NUM_OUT; i++) begin
      d_eff[i]   = (div_q[i] == '0) ? DIV_W'(1) : div_q[i];
      ph_eff[i]  = (ph_q[i] < d_eff[i]) ? ph_q[i] : '0;
      half[i]    = ({1'b0, d_eff[i]} + (DIV_W+1)'(1)) >> 1;
      cnt_adv[i] = (cnt[i] == d_eff[i] - DIV_W'(1)) ? '0 : cnt[i] + DIV_W'(1);
    end
  end

  always_comb begin
    state_nx    = state;
    lock_cnt_nx = lock_cnt;
    div_nx      = div_q;
    ph_nx       = ph_q;
    cnt_nx      = cnt;
    clkout_nx   = clkout_q;
    ce_nx       = ce_q;
    locked_nx   = locked_q;
    ack_nx      = 1'b0;

    if (bus.CFG_LOAD) begin
      ack_nx = 1'b1;
      for (int i = 0; i < NUM_OUT; i++) begin
        div_nx[i] = bus.CFG_DIV[i*DIV_W +: DIV_W];
        ph_nx[i]  = bus.CFG_PHASE[i*DIV_W +: DIV_W];
      end
    end

    if (bus.CFG_LOAD || bus.PWRDWN) begin
      state_nx    = ST_WAIT;
      lock_cnt_nx = '0;
      clkout_nx   = '0;
      ce_nx       = '0;
      locked_nx   = 1'b0;
    end else begin
      case (state)
        ST_WAIT: begin
          clkout_nx = '0;
          ce_nx     = '0;
          locked_nx = 1'b0;
          if (lock_cnt == LCW'(LOCK_CYCLES - 1)) begin
            // All channels restart together here, which keeps them phase-aligned.
            state_nx  = ST_RUN;
            locked_nx = 1'b1;
            for (int i = 0; i < NUM_OUT; i++) begin
              cnt_nx[i]    = ph_eff[i];
              clkout_nx[i] = clk_of(ph_eff[i], half[i]);
              ce_nx[i]     = ce_of(ph_eff[i]);
            end
          end else begin
            lock_cnt_nx = lock_cnt + LCW'(1);
          end
        end
        ST_RUN: begin
          locked_nx = 1'b1;
          for (int i = 0; i < NUM_OUT; i++) begin
            cnt_nx[i]    = cnt_adv[i];
            clkout_nx[i] = clk_of(cnt_adv[i], half[i]);
            ce_nx[i]     = ce_of(cnt_adv[i]);
          end
        end
        default: begin
          state_nx    = ST_WAIT;
          lock_cnt_nx = '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLKIN1 or posedge RST) begin
    if (RST) begin
      state    <= ST_WAIT;
      lock_cnt <= '0;
      for (int i = 0; i < NUM_OUT; i++) begin
        div_q[i] <= DIV_W'(1);
        ph_q[i]  <= '0;
        cnt[i]   <= '0;
      end
      clkout_q <= '0;
      ce_q     <= '0;
      locked_q <= 1'b0;
      ack_q    <= 1'b0;
    end else begin
      state    <= state_nx;
      lock_cnt <= lock_cnt_nx;
      div_q    <= div_nx;
      ph_q     <= ph_nx;
      cnt      <= cnt_nx;
      clkout_q <= clkout_nx;
      ce_q     <= ce_nx;
      locked_q <= locked_nx;
      ack_q    <= ack_nx;
    end
  end

  assign bus.CFG_ACK = ack_q;
  assign bus.LOCKED  = locked_q;
  assign bus.CLKOUT  = clkout_q;
  assign bus.CE      = ce_q;

  a_quiet_when_unlocked: assert property (@(posedge CLKIN1) disable iff (RST)
    !locked_q |-> (clkout_q == '0 && ce_q == '0));

  a_ack_unlocks: assert property (@(posedge CLKIN1) disable iff (RST)
    ack_q |-> !locked_q);

endmodule

// File: tb/tb_clk_div_gen.sv
// Scoreboard bench for clk_div_gen: driver pushes model predictions per edge, monitor pops and compares.
module tb_clk_div_gen;
  localparam int N  = 3;
  localparam int W  = 4;
  localparam int LC = 8;

  logic CLKIN1 = 1'b0;
  logic RST    = 1'b0;

  clk_div_gen_if #(.NUM_OUT(N), .DIV_W(W)) bus ();

  clk_div_gen #(.NUM_OUT(N), .DIV_W(W), .LOCK_CYCLES(LC)) dut (
    .CLKIN1 (CLKIN1),
    .RST    (RST),
    .bus    (bus.slave)
  );

  always #5 CLKIN1 = ~CLKIN1;

  typedef struct packed {
    logic         ack;
    logic         locked;
    logic [N-1:0] clk;
    logic [N-1:0] ce;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // Reference model: configuration plus number of consecutive quiet edges since the last restart.
  int m_div [N];
  int m_ph  [N];
  int quiet;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_div[i] = 1;
      m_ph[i]  = 0;
    end
    quiet = 0;
  endtask

  task automatic model_edge(input bit pd, input bit ld, input logic [N*W-1:0] div,
                            input logic [N*W-1:0] ph, output exp_t e);
    int d, p, c;
    e     = '0;
    e.ack = ld;
    if (ld) begin
      for (int i = 0; i < N; i++) begin
        m_div[i] = int'(div[i*W +: W]);
        m_ph[i]  = int'(ph[i*W +: W]);
      end
    end
    if (ld || pd) quiet = 0;
    else          quiet++;
    if (quiet >= LC) begin
      e.locked = 1'b1;
      for (int i = 0; i < N; i++) begin
        d = (m_div[i] == 0) ? 1 : m_div[i];
        p = (m_ph[i] < d) ? m_ph[i] : 0;
        c = (p + quiet - LC) % d;
        e.clk[i] = (c < (d + 1) / 2);
        e.ce[i]  = (c == 0);
      end
    end
  endtask

  task automatic step(input bit pd, input bit ld, input logic [N*W-1:0] div,
                      input logic [N*W-1:0] ph);
    exp_t e;
    @(negedge CLKIN1);
    bus.PWRDWN    = pd;
    bus.CFG_LOAD  = ld;
    bus.CFG_DIV   = div;
    bus.CFG_PHASE = ph;
    model_edge(pd, ld, div, ph, e);
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, '0, '0);
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_locked"}, 32'(bus.LOCKED), 32'd0);
    chk({tag, "_clkout"}, 32'(bus.CLKOUT), 32'd0);
    chk({tag, "_ce"},     32'(bus.CE),     32'd0);
    chk({tag, "_ack"},    32'(bus.CFG_ACK), 32'd0);
  endtask

  // Asserts reset mid-cycle, checks the asynchronous clear, releases mid-high-phase so no edge goes unmodelled.
  task automatic pulse_reset(input string tag);
    @(negedge CLKIN1);
    #2 RST = 1'b1;
    bus.PWRDWN   = 1'b0;
    bus.CFG_LOAD = 1'b0;
    #1 check_cleared(tag);
    model_reset();
    repeat (2) @(negedge CLKIN1);
    @(posedge CLKIN1);
    #2 RST = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge CLKIN1);
      #1;
      if (!RST && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("ack",    32'(bus.CFG_ACK), 32'(e.ack));
        chk("locked", 32'(bus.LOCKED),  32'(e.locked));
        chk("clkout", 32'(bus.CLKOUT),  32'(e.clk));
        chk("ce",     32'(bus.CE),      32'(e.ce));
      end
    end
  end

  initial begin : driver
    logic [N*W-1:0] rdiv, rph;
    bit rpd, rld;
    bus.PWRDWN    = 1'b0;
    bus.CFG_LOAD  = 1'b0;
    bus.CFG_DIV   = '0;
    bus.CFG_PHASE = '0;
    model_reset();

    #1 RST = 1'b1;
    #2 check_cleared("reset");
    @(posedge CLKIN1);
    #2 RST = 1'b0;

    // Defaults: lock on edge 8, then all ones.
    idle(14);

    // Mid-run reset clears outputs immediately.
    pulse_reset("run_reset");
    idle(12);

    // Ratios {4,3,2}, phases {1,0,0}.
    step(1'b0, 1'b1, {4'd4, 4'd3, 4'd2}, {4'd1, 4'd0, 4'd0});
    idle(24);

    // Boundaries: D=0 on ch0, PH beyond D on ch1, max phase on ch2.
    step(1'b0, 1'b1, {4'd5, 4'd3, 4'd0}, {4'd4, 4'd5, 4'd9});
    idle(20);

    // Power-down in RUN for 20 cycles; configuration must survive.
    for (int k = 0; k < 20; k++) step(1'b1, 1'b0, '0, '0);
    idle(20);

    // Load with power-down together stays held, then relock.
    step(1'b1, 1'b1, {4'd7, 4'd2, 4'd15}, {4'd3, 4'd1, 4'd14});
    step(1'b1, 1'b0, '0, '0);
    idle(20);

    // Second load arriving at lock_cnt=6 restarts the count.
    step(1'b0, 1'b1, {4'd2, 4'd6, 4'd3}, {4'd0, 4'd2, 4'd1});
    idle(6);
    step(1'b0, 1'b1, {4'd3, 4'd6, 4'd4}, {4'd2, 4'd5, 4'd3});
    idle(20);

    // Reset at lock_cnt=5 returns to defaults with the full delay.
    step(1'b0, 1'b1, {4'd4, 4'd4, 4'd4}, {4'd1, 4'd2, 4'd3});
    idle(5);
    pulse_reset("wait_reset");
    idle(14);

    // Randomized traffic.
    for (int k = 0; k < 600; k++) begin
      rpd  = ($urandom_range(0, 39) == 0);
      rld  = ($urandom_range(0, 39) == 0);
      rdiv = N*W'($urandom);
      rph  = N*W'($urandom);
      step(rpd, rld, rdiv, rph);
    end
    idle(30);

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge CLKIN1);
    #2 chk("drain", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
